// File: rtl/spell_gpio_pkg.sv
// Shared constants, register view types and the register read selector for
// the spell memory-mapped GPIO block.
package spell_gpio_pkg;

  localparam logic [7:0] OFF_PIN  = 8'd0;
  localparam logic [7:0] OFF_DDR  = 8'd1;
  localparam logic [7:0] OFF_PORT = 8'd2;
  localparam logic [7:0] OFF_RISE = 8'd3;
  localparam logic [7:0] OFF_FALL = 8'd4;
  localparam logic [7:0] OFF_IFR  = 8'd5;
  localparam logic [7:0] OFF_IMSK = 8'd6;

  localparam int MAX_PORTS = 4;

  typedef struct packed {
    logic [7:0] pin;
    logic [7:0] ddr;
    logic [7:0] port;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] ifr;
    logic [7:0] imsk;
  } port_view_t;

  typedef struct packed {
    logic       ddr_we;
    logic       port_we;
    logic       rise_we;
    logic       fall_we;
    logic       imsk_we;
    logic       pin_toggle;
    logic [7:0] ifr_clear;
    logic [7:0] wdata;
  } port_wr_t;

  function automatic logic [7:0] reg_sel(input port_view_t v, input logic [7:0] off);
    logic [7:0] r;
    case (off)
      OFF_PIN:  r = v.pin;
      OFF_DDR:  r = v.ddr;
      OFF_PORT: r = v.port;
      OFF_RISE: r = v.rise;
      OFF_FALL: r = v.fall;
      OFF_IFR:  r = v.ifr;
      OFF_IMSK: r = v.imsk;
      default:  r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spell_gpio_port.sv
// One 8-bit GPIO port: input synchroniser, edge detector, sticky interrupt
// flags and the DDR/PORT/RISE/FALL/IMSK configuration registers.
module spell_gpio_port
  import spell_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] io_in,
  input  port_wr_t   wr,
  output port_view_t view
);

  logic [7:0] sync_r [SYNC_STAGES];
  logic [7:0] prev_r;
  logic [7:0] ddr_r, port_r, rise_r, fall_r, ifr_r, imsk_r;
  logic [7:0] rise_s, fall_s;

  assign rise_s = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign fall_s = ~sync_r[SYNC_STAGES-1] & prev_r;

  // Input synchroniser chain plus one-cycle edge history.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 8'h00;
      prev_r <= 8'h00;
    end else begin
      sync_r[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Configuration registers and sticky flags; a new edge beats a same-cycle clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ddr_r  <= 8'h00;
      port_r <= 8'h00;
      rise_r <= 8'h00;
      fall_r <= 8'h00;
      ifr_r  <= 8'h00;
      imsk_r <= 8'h00;
    end else begin
      if (wr.ddr_we)  ddr_r  <= wr.wdata;
      if (wr.rise_we) rise_r <= wr.wdata;
      if (wr.fall_we) fall_r <= wr.wdata;
      if (wr.imsk_we) imsk_r <= wr.wdata;
      if (wr.port_we)         port_r <= wr.wdata;
      else if (wr.pin_toggle) port_r <= port_r ^ wr.wdata;
      ifr_r <= (ifr_r & ~wr.ifr_clear) | (rise_s & rise_r) | (fall_s & fall_r);
    end
  end

  assign view = '{pin:  sync_r[SYNC_STAGES-1],
                  ddr:  ddr_r,
                  port: port_r,
                  rise: rise_r,
                  fall: fall_r,
                  ifr:  ifr_r,
                  imsk: imsk_r};

endmodule

// File: rtl/spell_mem_gpio.sv
// Multi-port memory-mapped GPIO for the spell 8-bit bus: address decode,
// first-cycle write tracking, registered read mux and irq reduction.
module spell_mem_gpio
  import spell_gpio_pkg::*;
#(
  parameter int         NUM_PORTS   = 2,
  parameter logic [7:0] BASE_ADDR   = 8'h36,
  parameter int         STRIDE      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   select,
  input  logic [7:0]             addr,
  input  logic [7:0]             data_in,
  input  logic                   write,
  output logic [7:0]             data_out,
  output logic                   data_ready,
  input  logic [8*NUM_PORTS-1:0] io_in,
  output logic [8*NUM_PORTS-1:0] io_out,
  output logic [8*NUM_PORTS-1:0] io_oeb,
  output logic                   irq
);

  localparam int END_ADDR    = int'(BASE_ADDR) + NUM_PORTS * STRIDE;
  localparam int STRIDE_LOG2 = $clog2(STRIDE);

  if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("spell_mem_gpio: NUM_PORTS out of range");
  end
  if (END_ADDR > 256) begin : g_bad_map
    $error("spell_mem_gpio: port map exceeds the 8-bit address space");
  end
  if (STRIDE < 8 || (STRIDE & (STRIDE - 1)) != 0) begin : g_bad_stride
    $error("spell_mem_gpio: STRIDE must be a power of two >= 8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spell_mem_gpio: SYNC_STAGES must be >= 2");
  end

  logic [7:0] rel_s, port_idx_s, offset_s, rd_s;
  logic       valid_s, first_write_s, past_write_r, irq_next_s;
  port_view_t view_s [NUM_PORTS];

  // Address decode; the subtraction is only meaningful once the range check holds.
  always_comb begin
    rel_s         = addr - BASE_ADDR;
    port_idx_s    = rel_s >> STRIDE_LOG2;
    offset_s      = rel_s & 8'(STRIDE - 1);
    valid_s       = (addr >= BASE_ADDR) && ({1'b0, addr} < 9'(END_ADDR)) && (offset_s <= OFF_IMSK);
    first_write_s = select && write && !past_write_r;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_wr_t wr_s;
    logic     hit_s;

    // Per-port write strobes; toggles and clears fire only on the first held cycle.
    always_comb begin
      hit_s              = select && write && valid_s && (port_idx_s == 8'(p));
      wr_s.wdata         = data_in;
      wr_s.ddr_we        = hit_s && (offset_s == OFF_DDR);
      wr_s.port_we       = hit_s && (offset_s == OFF_PORT);
      wr_s.rise_we       = hit_s && (offset_s == OFF_RISE);
      wr_s.fall_we       = hit_s && (offset_s == OFF_FALL);
      wr_s.imsk_we       = hit_s && (offset_s == OFF_IMSK);
      wr_s.pin_toggle    = hit_s && first_write_s && (offset_s == OFF_PIN);
      wr_s.ifr_clear     = (hit_s && first_write_s && (offset_s == OFF_IFR)) ? data_in : 8'h00;
    end

    spell_gpio_port #(.SYNC_STAGES(SYNC_STAGES)) u_port (
      .clock   (clock),
      .reset_n (reset_n),
      .io_in   (io_in[8*p +: 8]),
      .wr      (wr_s),
      .view    (view_s[p])
    );

    assign io_out[8*p +: 8] = view_s[p].port;
    assign io_oeb[8*p +: 8] = ~view_s[p].ddr;
  end

  // Read mux and interrupt reduction across ports.
  always_comb begin
    rd_s       = 8'h00;
    irq_next_s = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_s       = rd_s | ((valid_s && (port_idx_s == 8'(p))) ? reg_sel(view_s[p], offset_s) : 8'h00);
      irq_next_s = irq_next_s | (|(view_s[p].ifr & view_s[p].imsk));
    end
  end

  // Bus handshake, write history and registered irq.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out     <= 8'h00;
      data_ready   <= 1'b0;
      past_write_r <= 1'b0;
      irq          <= 1'b0;
    end else begin
      data_ready   <= select;
      past_write_r <= select && write;
      irq          <= irq_next_s;
      if (select) data_out <= write ? 8'h00 : rd_s;
    end
  end

endmodule

// File: doc/spell_mem_gpio.md
Name: spell_mem_gpio

Overview:
- Parametrised successor of the single-port memory-mapped GPIO block on the spell 8-bit data bus.
- Provides NUM_PORTS 8-bit GPIO ports, each with PIN/DDR/PORT registers, a synchroniser on the inputs, per-pin rising/falling edge detection, sticky interrupt flags and a masked irq output.
- Sits on the spell memory bus beside other I/O peripherals. With defaults, port 0 PIN/DDR/PORT occupy 8'h36/8'h37/8'h38, so existing firmware keeps working.

Parameters:
- NUM_PORTS, 2, number of 8-bit ports (1..4).
- BASE_ADDR, 8'h36, address of port 0 PIN.
- STRIDE, 8, address step between ports; power of two, >= 8.
- SYNC_STAGES, 2, input synchroniser depth (>= 2).
- Constraint: BASE_ADDR + NUM_PORTS*STRIDE <= 256. Elaboration error otherwise.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- select  in  1  bus access strobe.
- addr  in  8  byte address.
- data_in  in  8  write data.
- write  in  1  1 = write, 0 = read.
- data_out  out  8  registered read data.
- data_ready  out  1  access acknowledge.
- io_in  in  8*NUM_PORTS  pad inputs; port p uses bits [8p+7:8p].
- io_out  out  8*NUM_PORTS  pad output values.
- io_oeb  out  8*NUM_PORTS  pad output enables, active low.
- irq  out  1  level interrupt = OR over ports of (IFR & IMSK).

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - io_out=0, io_oeb=all 1s, data_out=0, data_ready=0, irq=0.
  - All DDR/PORT/RISE/FALL/IFR/IMSK, synchroniser and edge-history flops reset to 0.
  - Reset mid-access aborts the access; it has no side effects.
- Decode:
  - Port p = (addr-BASE_ADDR)/STRIDE, offset = (addr-BASE_ADDR)%STRIDE.
  - The access is valid only when addr is in [BASE_ADDR, BASE_ADDR+NUM_PORTS*STRIDE) and offset <= 6.
- Offsets:
  - 0 PIN: read returns the synchronised input. Write XORs data_in into PORT.
  - 1 DDR: read/write ~io_oeb. 1 = output.
  - 2 PORT: read/write io_out.
  - 3 RISE: rising-edge enable mask.
  - 4 FALL: falling-edge enable mask.
  - 5 IFR: read returns flags. Write 1 clears a flag.
  - 6 IMSK: irq mask.
- Handshake:
  - In any cycle with select=1, the next edge sets data_ready=1 and data_out = read data.
  - Read data is 0 for writes, unmapped offsets and out-of-range addresses.
  - The cycle after select=0, data_ready=0. data_out holds its value.
  - Read latency is 1 cycle.
- Held writes:
  - A write may be held for several cycles.
  - Non-idempotent writes (PIN toggle, IFR clear) take effect only on the first cycle of select&write, tracked with a registered past_write.
  - Idempotent writes (DDR, PORT, RISE, FALL, IMSK) apply every cycle they are held.
- Synchroniser and PIN latency:
  - io_in passes through SYNC_STAGES flops to give sync.
  - A PIN read reflects io_in as of SYNC_STAGES+1 edges earlier.
- Edge detection:
  - prev is sync delayed by 1 cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
  - IFR_next = (IFR & ~clear) | (rise & RISE) | (fall & FALL).
  - When a set and a clear hit the same bit in the same cycle, set wins.
- irq is registered: it updates one edge after IFR or IMSK changes.
- Output pads: io_oeb = ~DDR. Pins configured as inputs still drive io_out internally; the pad ignores it.
- Width rules: all arithmetic is 8-bit. Address subtraction is unsigned and guarded by the range compare.

Decomposition:
- Package spell_gpio_pkg holds:
  - offset localparams: OFF_PIN=0, OFF_DDR=1, OFF_PORT=2, OFF_RISE=3, OFF_FALL=4, OFF_IFR=5, OFF_IMSK=6.
  - the MAX_PORTS=4 constant.
- Sub-module spell_gpio_port: one 8-bit port's registers, synchroniser, edge detector and IFR. Instantiated NUM_PORTS times by generate.
- Top level keeps the bus decode, the past_write tracking, the read mux and the irq reduction.

Test Plan:
- Reset then read 8'h37 -> data_out=8'h00, data_ready=1 one cycle after select. io_oeb=16'hFFFF.
- Write 8'h0F to 8'h37, then 8'hA5 to 8'h38 -> io_oeb[7:0]=8'hF0, io_out[7:0]=8'hA5. Reading back both returns the written values.
- Hold a write of 8'h01 to PIN (8'h36) for 3 cycles with PORT=8'hA5 -> PORT=8'hA4, toggled exactly once. Repeat on 8'h3E (port 1 PIN).
- Set port 1 RISE (8'h41)=8'h80 and IMSK (8'h44)=8'h80, then drive io_in[15] 0->1:
  - IFR (8'h43) reads 8'h80.
  - irq rises within SYNC_STAGES+3 cycles.
  - Writing 8'h80 to 8'h43 clears the flag and drops irq next cycle.
- Drive a new rising edge on the same cycle as the W1C clear of that bit -> flag stays 1, irq stays 1.
- Read 8'h3D (port 0, offset 7) and 8'h46 (beyond NUM_PORTS=2) -> data_out=0, data_ready=1, no state change. Assert reset_n=0 during a held write -> all outputs return to reset values next edge.
